// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath and the microcoded control unit:
// widths, bus-select codes, strobe bit positions and ALU op codes.
package datapath_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 6;

  // Bus source select codes carried on read_en.
  typedef enum logic [3:0] {
    SEL_NONE = 4'd0,
    SEL_PC   = 4'd1,
    SEL_AR   = 4'd2,
    SEL_IR   = 4'd4,
    SEL_AC   = 4'd5,
    SEL_R    = 4'd6,
    SEL_R1   = 4'd7,
    SEL_R2   = 4'd8,
    SEL_R3   = 4'd9,
    SEL_R4   = 4'd10,
    SEL_DM   = 4'd12,
    SEL_IM   = 4'd13
  } bus_sel_e;

  // Bit positions shared by write_en, inc_en and clr_en.
  localparam int unsigned EN_PC     = 1;
  localparam int unsigned EN_AR     = 2;
  localparam int unsigned EN_IR     = 3;
  localparam int unsigned EN_AC     = 4;
  localparam int unsigned EN_R      = 5;
  localparam int unsigned EN_R4     = 7;
  localparam int unsigned EN_R3     = 8;
  localparam int unsigned EN_R2     = 9;
  localparam int unsigned EN_R1     = 10;
  localparam int unsigned EN_DMW    = 11;
  localparam int unsigned EN_ALU2AC = 12;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_MUL = 3'd3,
    ALU_LSH = 3'd4
  } alu_op_e;

  // Common register next-state: clear beats load beats increment beats hold.
  function automatic logic [DW-1:0] next_reg(input logic [DW-1:0] q,
                                             input logic [DW-1:0] bus,
                                             input logic          clr,
                                             input logic          wr,
                                             input logic          inc);
    logic [DW-1:0] nxt;
    if (clr) begin
      nxt = '0;
    end else if (wr) begin
      nxt = bus;
    end else if (inc) begin
      nxt = q + 1'b1;
    end else begin
      nxt = q;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control strobes plus instruction/data memory bus seen by the datapath.
// master = control unit / memories side, slave = datapath side.
interface datapath_if;

  logic [3:0]                       read_en;
  logic [15:0]                      write_en;
  logic [15:0]                      inc_en;
  logic [15:0]                      clr_en;
  logic [2:0]                       alu_op;
  logic [datapath_pkg::DW-1:0]      im_rdata;
  logic [datapath_pkg::DW-1:0]      dm_rdata;
  logic [datapath_pkg::DW-1:0]      im_addr;
  logic [datapath_pkg::DW-1:0]      dm_addr;
  logic [datapath_pkg::DW-1:0]      dm_wdata;
  logic                             dm_we;
  logic [datapath_pkg::OPW-1:0]     instruction;
  logic [datapath_pkg::DW-1:0]      z;

  modport master (
    output read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
    input  im_addr, dm_addr, dm_wdata, dm_we, instruction, z
  );

  modport slave (
    input  read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
    output im_addr, dm_addr, dm_wdata, dm_we, instruction, z
  );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A is AC, B is R. Carries, borrows and overflow are dropped.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result
);

  // Select the operation; unused codes fall back to passing A.
  always_comb begin
    result = a;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_MUL: result = a * b;
      ALU_LSH: result = {a[DW-2:0], 1'b0};
      default: result = a;
    endcase
  end

endmodule

// File: rtl/datapath_core.sv
// Register file, shared bus and ALU of the microcoded CPU datapath.
module datapath_core
  import datapath_pkg::*;
(
  input logic      clk,
  input logic      rst,
  datapath_if.slave dp
);

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ar_q, ar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] ac_q, ac_d;
  logic [DW-1:0] r_q,  r_d;
  logic [DW-1:0] r1_q, r1_d;
  logic [DW-1:0] r2_q, r2_d;
  logic [DW-1:0] r3_q, r3_d;
  logic [DW-1:0] r4_q, r4_d;
  logic [DW-1:0] bus;
  logic [DW-1:0] alu_res;

  // Strobe bits with no register behind them.
  logic unused_strobes;
  assign unused_strobes = ^{dp.write_en[0], dp.write_en[6], dp.write_en[15:13],
                            dp.inc_en[0], dp.inc_en[6], dp.inc_en[15:11],
                            dp.clr_en[0], dp.clr_en[6], dp.clr_en[15:11]};

  datapath_alu u_alu (
    .a      (ac_q),
    .b      (r_q),
    .op     (dp.alu_op),
    .result (alu_res)
  );

  // Shared bus source mux; unassigned codes drive zero.
  always_comb begin
    bus = '0;
    case (dp.read_en)
      SEL_PC:  bus = pc_q;
      SEL_AR:  bus = ar_q;
      SEL_IR:  bus = ir_q;
      SEL_AC:  bus = ac_q;
      SEL_R:   bus = r_q;
      SEL_R1:  bus = r1_q;
      SEL_R2:  bus = r2_q;
      SEL_R3:  bus = r3_q;
      SEL_R4:  bus = r4_q;
      SEL_DM:  bus = dp.dm_rdata;
      SEL_IM:  bus = dp.im_rdata;
      default: bus = '0;
    endcase
  end

  // Next-state per register; AC additionally accepts the ALU result ahead of a bus load.
  always_comb begin
    pc_d = next_reg(pc_q, bus, dp.clr_en[EN_PC], dp.write_en[EN_PC], dp.inc_en[EN_PC]);
    ar_d = next_reg(ar_q, bus, dp.clr_en[EN_AR], dp.write_en[EN_AR], dp.inc_en[EN_AR]);
    ir_d = next_reg(ir_q, bus, dp.clr_en[EN_IR], dp.write_en[EN_IR], dp.inc_en[EN_IR]);
    r_d  = next_reg(r_q,  bus, dp.clr_en[EN_R],  dp.write_en[EN_R],  dp.inc_en[EN_R]);
    r1_d = next_reg(r1_q, bus, dp.clr_en[EN_R1], dp.write_en[EN_R1], dp.inc_en[EN_R1]);
    r2_d = next_reg(r2_q, bus, dp.clr_en[EN_R2], dp.write_en[EN_R2], dp.inc_en[EN_R2]);
    r3_d = next_reg(r3_q, bus, dp.clr_en[EN_R3], dp.write_en[EN_R3], dp.inc_en[EN_R3]);
    r4_d = next_reg(r4_q, bus, dp.clr_en[EN_R4], dp.write_en[EN_R4], dp.inc_en[EN_R4]);
    if (dp.clr_en[EN_AC]) begin
      ac_d = '0;
    end else if (dp.write_en[EN_ALU2AC]) begin
      ac_d = alu_res;
    end else begin
      ac_d = next_reg(ac_q, bus, 1'b0, dp.write_en[EN_AC], dp.inc_en[EN_AC]);
    end
  end

  // Register bank; synchronous reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      ar_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
      r_q  <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
      r_q  <= r_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      r4_q <= r4_d;
    end
  end

  assign dp.im_addr     = pc_q;
  assign dp.dm_addr     = ar_q;
  assign dp.dm_wdata    = bus;
  assign dp.dm_we       = dp.write_en[EN_DMW] & ~rst;
  assign dp.instruction = ir_q[OPW-1:0];
  assign dp.z           = {{(DW-1){1'b0}}, (ac_q == '0)};

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core; register contents are observed by
// routing them onto the bus and reading dm_wdata.
module tb_datapath_core;
  import datapath_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  datapath_if dp_if ();

  datapath_core u_dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    dp_if.read_en  = 4'd0;
    dp_if.write_en = 16'h0000;
    dp_if.inc_en   = 16'h0000;
    dp_if.clr_en   = 16'h0000;
    dp_if.alu_op   = 3'd0;
  endtask

  // One posedge, then drop all strobes and let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  // Load register at strobe bit en with val via dm_rdata on the bus.
  task automatic load_reg(input int en, input logic [15:0] val);
    dp_if.dm_rdata     = val;
    dp_if.read_en      = SEL_DM;
    dp_if.write_en[en] = 1'b1;
    step();
  endtask

  task automatic peek(input logic [3:0] sel, output logic [15:0] val);
    dp_if.read_en = sel;
    #1;
    val = dp_if.dm_wdata;
    dp_if.read_en = 4'd0;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    idle();
    dp_if.im_rdata = 16'h0;
    dp_if.dm_rdata = 16'h0;
    rst = 1'b1;
    step();
    step();
    tests++;
    if (dp_if.im_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_im_addr got %h want 0000", dp_if.im_addr);
    end
    tests++;
    if (dp_if.instruction !== 6'h00) begin
      fails++; $display("FAIL reset_instruction got %h want 00", dp_if.instruction);
    end
    tests++;
    if (dp_if.z !== 16'h0001) begin
      fails++; $display("FAIL reset_z got %h want 0001", dp_if.z);
    end
    tests++;
    if (dp_if.dm_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_dm_addr got %h want 0000", dp_if.dm_addr);
    end
    // dm_we is gated off while rst is high even with its strobe raised.
    dp_if.write_en[EN_DMW] = 1'b1;
    #1;
    tests++;
    if (dp_if.dm_we !== 1'b0) begin
      fails++; $display("FAIL reset_dm_we got %b want 0", dp_if.dm_we);
    end
    step();
    rst = 1'b0;
    #1;
    peek(SEL_R, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++; $display("FAIL reset_r got %h want 0000", v);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] v;
    dp_if.im_rdata = 16'h0143;
    dp_if.read_en  = SEL_IM;
    dp_if.write_en[EN_IR] = 1'b1;
    #1;
    tests++;
    if (dp_if.dm_wdata !== 16'h0143) begin
      fails++; $display("FAIL fetch_bus got %h want 0143", dp_if.dm_wdata);
    end
    step();
    dp_if.inc_en[EN_PC] = 1'b1;
    step();
    tests++;
    if (dp_if.instruction !== 6'h03) begin
      fails++; $display("FAIL fetch_instruction got %h want 03", dp_if.instruction);
    end
    peek(SEL_IR, v);
    tests++;
    if (v !== 16'h0143) begin
      fails++; $display("FAIL fetch_ir got %h want 0143", v);
    end
    tests++;
    if (dp_if.im_addr !== 16'h0001) begin
      fails++; $display("FAIL fetch_pc got %h want 0001", dp_if.im_addr);
    end
  endtask

  task automatic test_load_store();
    logic [15:0] v;
    load_reg(EN_AC, 16'h0020);
    dp_if.read_en = SEL_AC;
    dp_if.write_en[EN_AR] = 1'b1;
    step();
    tests++;
    if (dp_if.dm_addr !== 16'h0020) begin
      fails++; $display("FAIL ls_dm_addr got %h want 0020", dp_if.dm_addr);
    end
    load_reg(EN_AC, 16'h1234);
    peek(SEL_AC, v);
    tests++;
    if (v !== 16'h1234) begin
      fails++; $display("FAIL ls_ac got %h want 1234", v);
    end
    tests++;
    if (dp_if.dm_we !== 1'b0) begin
      fails++; $display("FAIL ls_we_before got %b want 0", dp_if.dm_we);
    end
    dp_if.read_en = SEL_AC;
    dp_if.write_en[EN_DMW] = 1'b1;
    #1;
    tests++;
    if (dp_if.dm_we !== 1'b1 || dp_if.dm_wdata !== 16'h1234) begin
      fails++; $display("FAIL ls_store got we=%b data=%h want we=1 data=1234",
                        dp_if.dm_we, dp_if.dm_wdata);
    end
    step();
    tests++;
    if (dp_if.dm_we !== 1'b0) begin
      fails++; $display("FAIL ls_we_after got %b want 0", dp_if.dm_we);
    end
  endtask

  task automatic test_alu();
    logic [2:0]  ops [6]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6};
    logic [15:0] exps [6] = '{16'd10, 16'd4, 16'd21, 16'd14, 16'd7, 16'd7};
    logic [15:0] v;
    for (int i = 0; i < 6; i++) begin
      load_reg(EN_AC, 16'd7);
      load_reg(EN_R, 16'd3);
      dp_if.alu_op = ops[i];
      dp_if.write_en[EN_ALU2AC] = 1'b1;
      step();
      peek(SEL_AC, v);
      tests++;
      if (v !== exps[i]) begin
        fails++; $display("FAIL alu_op%0d got %h want %h", ops[i], v, exps[i]);
      end
    end
    load_reg(EN_AC, 16'd3);
    load_reg(EN_R, 16'd3);
    dp_if.alu_op = ALU_SUB;
    dp_if.write_en[EN_ALU2AC] = 1'b1;
    step();
    tests++;
    if (dp_if.z !== 16'h0001) begin
      fails++; $display("FAIL alu_sub_zero_z got %h want 0001", dp_if.z);
    end
    load_reg(EN_AC, 16'hFFFF);
    load_reg(EN_R, 16'd2);
    dp_if.alu_op = ALU_MUL;
    dp_if.write_en[EN_ALU2AC] = 1'b1;
    step();
    peek(SEL_AC, v);
    tests++;
    if (v !== 16'hFFFE) begin
      fails++; $display("FAIL alu_mul_wrap got %h want fffe", v);
    end
    tests++;
    if (dp_if.z !== 16'h0000) begin
      fails++; $display("FAIL alu_nonzero_z got %h want 0000", dp_if.z);
    end
  endtask

  task automatic test_priority();
    logic [15:0] v;
    load_reg(EN_PC, 16'h0055);
    tests++;
    if (dp_if.im_addr !== 16'h0055) begin
      fails++; $display("FAIL prio_pc_load got %h want 0055", dp_if.im_addr);
    end
    dp_if.dm_rdata = 16'h1111;
    dp_if.read_en  = SEL_DM;
    dp_if.clr_en[EN_PC] = 1'b1;
    dp_if.write_en[EN_PC] = 1'b1;
    dp_if.inc_en[EN_PC] = 1'b1;
    step();
    tests++;
    if (dp_if.im_addr !== 16'h0000) begin
      fails++; $display("FAIL prio_clr got %h want 0000", dp_if.im_addr);
    end
    load_reg(EN_AC, 16'd7);
    load_reg(EN_R, 16'd3);
    dp_if.dm_rdata = 16'h9999;
    dp_if.read_en  = SEL_DM;
    dp_if.alu_op   = ALU_ADD;
    dp_if.write_en[EN_AC] = 1'b1;
    dp_if.write_en[EN_ALU2AC] = 1'b1;
    step();
    peek(SEL_AC, v);
    tests++;
    if (v !== 16'd10) begin
      fails++; $display("FAIL prio_alu_over_bus got %h want 000a", v);
    end
    dp_if.dm_rdata = 16'h0200;
    dp_if.read_en  = SEL_DM;
    dp_if.write_en[EN_PC] = 1'b1;
    dp_if.inc_en[EN_PC] = 1'b1;
    step();
    tests++;
    if (dp_if.im_addr !== 16'h0200) begin
      fails++; $display("FAIL prio_write_over_inc got %h want 0200", dp_if.im_addr);
    end
    load_reg(EN_AC, 16'hFFFF);
    dp_if.inc_en[EN_AC] = 1'b1;
    step();
    tests++;
    if (dp_if.z !== 16'h0001) begin
      fails++; $display("FAIL inc_wrap_z got %h want 0001", dp_if.z);
    end
    load_reg(EN_AR, 16'hFFFF);
    dp_if.inc_en[EN_AR] = 1'b1;
    step();
    tests++;
    if (dp_if.dm_addr !== 16'h0000) begin
      fails++; $display("FAIL inc_wrap_ar got %h want 0000", dp_if.dm_addr);
    end
  endtask

  task automatic test_moves();
    logic [15:0] v;
    logic [3:0]  sels [4] = '{SEL_R1, SEL_R2, SEL_R3, SEL_R4};
    logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    load_reg(EN_R1, 16'h1111);
    load_reg(EN_R2, 16'h2222);
    load_reg(EN_R3, 16'h3333);
    load_reg(EN_R4, 16'h4444);
    for (int i = 0; i < 4; i++) begin
      peek(sels[i], v);
      tests++;
      if (v !== vals[i]) begin
        fails++; $display("FAIL move_rn%0d got %h want %h", i + 1, v, vals[i]);
      end
    end
    // All four general registers loaded in a single cycle.
    dp_if.dm_rdata = 16'h5A5A;
    dp_if.read_en  = SEL_DM;
    dp_if.write_en[EN_R1] = 1'b1;
    dp_if.write_en[EN_R2] = 1'b1;
    dp_if.write_en[EN_R3] = 1'b1;
    dp_if.write_en[EN_R4] = 1'b1;
    step();
    peek(SEL_R3, v);
    tests++;
    if (v !== 16'h5A5A) begin
      fails++; $display("FAIL move_simul_r3 got %h want 5a5a", v);
    end
    load_reg(EN_AC, 16'hBEEF);
    dp_if.read_en = SEL_AC;
    dp_if.write_en[EN_R1] = 1'b1;
    step();
    dp_if.clr_en[EN_AC] = 1'b1;
    step();
    tests++;
    if (dp_if.z !== 16'h0001) begin
      fails++; $display("FAIL move_ac_clear got z=%h want 0001", dp_if.z);
    end
    dp_if.read_en = SEL_R1;
    dp_if.write_en[EN_AC] = 1'b1;
    step();
    peek(SEL_AC, v);
    tests++;
    if (v !== 16'hBEEF) begin
      fails++; $display("FAIL move_r1_to_ac got %h want beef", v);
    end
    dp_if.im_rdata = 16'h0A18;
    dp_if.read_en  = SEL_IM;
    dp_if.write_en[EN_IR] = 1'b1;
    step();
    dp_if.read_en = SEL_IR;
    dp_if.write_en[EN_PC] = 1'b1;
    step();
    tests++;
    if (dp_if.im_addr !== 16'h0A18) begin
      fails++; $display("FAIL jump_pc got %h want 0a18", dp_if.im_addr);
    end
    // Reset arriving mid-instruction wins over the jump strobes.
    load_reg(EN_PC, 16'h0001);
    dp_if.read_en = SEL_IR;
    dp_if.write_en[EN_PC] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (dp_if.im_addr !== 16'h0000 || dp_if.instruction !== 6'h00 ||
        dp_if.z !== 16'h0001) begin
      fails++; $display("FAIL jump_reset got pc=%h instr=%h z=%h want 0000/00/0001",
                        dp_if.im_addr, dp_if.instruction, dp_if.z);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_fetch();
    test_load_store();
    test_alu();
    test_priority();
    test_moves();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
# datapath_core

Register-file and bus datapath that responds to the microcoded control unit's per-state strobes (`read_en`, `write_en`, `inc_en`, `clr_en`, `alu_op`). It holds PC, AR, IR, AC, R and R1–R4, drives the single shared 16-bit bus, runs the ALU, and returns `instruction` and `z` to the control unit. It also presents the address, data and write-enable signals for the external instruction memory (IM) and data memory (DM).

## Interface
- `DW`, 16: data and register width.
- `OPW`, 6: opcode width returned to control.
- `clk` input 1: sole clock. Registers update on posedge; control changes state on negedge.
- `rst` input 1: synchronous, active-high reset.
- `read_en` input 4: bus source select.
- `write_en` input 16: per-register load strobes.
- `inc_en` input 16: per-register increment strobes.
- `clr_en` input 16: per-register clear strobes.
- `alu_op` input 3: ALU operation.
- `im_rdata` input DW: IM read data. Combinational with respect to `im_addr`.
- `dm_rdata` input DW: DM read data. Combinational with respect to `dm_addr`.
- `im_addr` output DW: equals PC.
- `dm_addr` output DW: equals AR.
- `dm_wdata` output DW: equals the bus.
- `dm_we` output 1: equals `write_en[11]`; forced to 0 while `rst` is high.
- `instruction` output OPW: equals IR[5:0].
- `z` output 16: {15'b0, AC==0}.

## Operation
- Strobe bit map, shared by `write_en`, `inc_en` and `clr_en`:
  - 1 = PC, 2 = AR, 3 = IR, 4 = AC, 5 = R
  - 7 = R4, 8 = R3, 9 = R2, 10 = R1
  - 11 = DM write (`write_en` only)
  - 12 = ALU→AC (`write_en` only)
  - Bits 0, 6, 13, 14, 15 are ignored.
- Bus mux is combinational on `read_en`:
  - 1 = PC, 2 = AR, 4 = IR, 5 = AC, 6 = R
  - 7 = R1, 8 = R2, 9 = R3, 10 = R4
  - 12 = `dm_rdata`, 13 = `im_rdata`
  - All other codes (0, 3, 11, 14, 15) drive 0.
- Per-register update priority, evaluated at posedge: `rst` > clr > write (load bus) > inc (+1, wrap modulo 2^DW) > hold.
- AC priority: `rst` > `clr_en[4]` > `write_en[12]` (load ALU result) > `write_en[4]` (load bus) > `inc_en[4]` > hold.
- ALU (combinational):
  - Operands: A = AC, B = R.
  - 0 = pass A, 1 = A+B, 2 = A−B, 3 = low DW bits of A×B, 4 = A<<1 (zero fill).
  - Codes 5–7 pass A.
  - Overflow, borrow and carry are discarded. No flags other than `z`.
- Jump: a load of PC takes the full bus value. Control places IR on the bus for this.
- Simultaneous strobes on different registers are all honoured in the same cycle.

## Timing
- Reset values: every register is 0. Consequently `im_addr`, `dm_addr` and `instruction` are 0, `z` = 16'h0001, and `dm_we` = 0.
- Register load latency is 1 cycle: the value is visible immediately after the posedge on which the strobe was sampled.
- `z` and `instruction` are combinational from AC and IR. They are stable for the control's negedge state update.
- `dm_we` and `dm_wdata` are combinational. DM captures on its own posedge. Control holds `read_en`=5 for the cycle before the write so the bus is settled.
- Reset asserted mid-instruction clears all registers on that posedge, regardless of strobes.
- Inc of 16'hFFFF gives 0. Inc of AC from 16'hFFFF gives `z`=1 in the next cycle.

## Structure
- Shared package `datapath_pkg`:
  - bus-select codes (`SEL_PC` … `SEL_IM`)
  - strobe bit indices (`EN_PC` … `EN_ALU2AC`)
  - ALU op codes (`ALU_NOP`, `ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_LSH`)
- The control unit imports the same package.
- One sub-module, `datapath_alu`: purely combinational, with ports A, B, op and result. All register, mux and priority logic lives in `datapath_core`.

## Test plan
- Reset, then hold `rst` 1 cycle with all strobes at 0: `im_addr`=0, `instruction`=0, `z`=16'h0001, `dm_we`=0.
- Fetch sequence:
  - Stimulus: `im_rdata`=16'h0143, `read_en`=13, `write_en[3]`=1, then `inc_en[1]`=1.
  - Required: IR=16'h0143, `instruction`=6'h03, PC=1.
- Load/store:
  - Stimulus: AC=16'h0020, `read_en`=5 with `write_en[2]`; `dm_rdata`=16'h1234, `read_en`=12 with `write_en[4]`; then `read_en`=5 with `write_en[11]`.
  - Required: `dm_addr`=16'h0020, AC=16'h1234, `dm_wdata`=16'h1234, `dm_we`=1 for exactly that cycle.
- ALU, with AC=7 and R=3:
  - op 1 → AC=10, op 2 → AC=4, op 3 → AC=21, op 4 → AC=14.
  - AC=3, R=3, op 2 → AC=0 and `z`=1.
  - AC=16'hFFFF, R=2, op 3 → AC=16'hFFFE.
- Priority collisions:
  - `clr_en[1]`, `write_en[1]` and `inc_en[1]` all asserted: PC=0.
  - `write_en[4]` and `write_en[12]` both asserted: AC takes the ALU result.
  - `write_en[1]` and `inc_en[1]` both asserted: PC takes the bus value.
- Register moves and jump:
  - AC=16'hBEEF → R1 (via `write_en[10]`) → clear AC → R1 to AC (via `read_en`=7): AC=16'hBEEF.
  - IR=16'h0A18, `read_en`=4 with `write_en[1]`: PC=16'h0A18.
  - `rst` asserted during that cycle: PC=0.
